// File: rtl/neopixel_pkg.sv
// Shared types and default timing for the WS2812 frame controller.
package neopixel_pkg;

  localparam int NUM_PIXELS    = 8;
  localparam int T0H_DEFAULT   = 18;
  localparam int T1H_DEFAULT   = 40;
  localparam int BIT_DEFAULT   = 63;
  localparam int LATCH_DEFAULT = 2600;

  typedef logic [23:0] grb_t;

  typedef enum logic [1:0] {
    IDLE,
    BIT_HI,
    BIT_LO,
    LATCH
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/neopixel_if.sv
// Load/go host port and serial line of the NeoPixel controller.
interface neopixel_if;

  logic [2:0] pixel;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       load;
  logic       go;
  logic       ready;
  logic       neo_data;

  modport master (output pixel, red, green, blue, load, go, input ready, neo_data);
  modport slave  (input pixel, red, green, blue, load, go, output ready, neo_data);

endinterface

// File: rtl/neo_bit_timer.sv
// Per-bit cycle counter; also times the latch gap so one counter serves the frame.
module neo_bit_timer
  import neopixel_pkg::*;
#(
  parameter int T0H_CYC   = T0H_DEFAULT,
  parameter int T1H_CYC   = T1H_DEFAULT,
  parameter int BIT_CYC   = BIT_DEFAULT,
  parameter int LATCH_CYC = LATCH_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic latching,
  input  logic bit_value,
  output logic bit_high_done,
  output logic bit_done
);

  localparam int CNT_W = $clog2(max2(BIT_CYC, LATCH_CYC) + 1);
  localparam logic [CNT_W-1:0] T0H_LAST   = CNT_W'(T0H_CYC - 1);
  localparam logic [CNT_W-1:0] T1H_LAST   = CNT_W'(T1H_CYC - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_high_done = (cnt == (bit_value ? T1H_LAST : T0H_LAST));
  assign bit_done      = (cnt == (latching ? LATCH_LAST : BIT_LAST));

  // Restarting from zero at every boundary keeps bit timing drift-free.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      cnt <= '0;
    end else if (!active || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/neopixel_controller.sv
// 8-pixel WS2812 frame controller. Define NEOPIXEL_DIM_EN to store each colour byte >> 2.
module neopixel_controller
  import neopixel_pkg::*;
#(
  parameter int T0H_CYC   = T0H_DEFAULT,
  parameter int T1H_CYC   = T1H_DEFAULT,
  parameter int BIT_CYC   = BIT_DEFAULT,
  parameter int LATCH_CYC = LATCH_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  neopixel_if.slave  bus
);

  localparam int PIX_W = $clog2(NUM_PIXELS);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);
  localparam logic [4:0]       TOP_BIT  = 5'd23;

  grb_t             buffer [NUM_PIXELS];
  grb_t             wr_data;
  state_t           state;
  logic [PIX_W-1:0] pix_cnt;
  logic [4:0]       bit_cnt;
  logic             neo_q;
  logic             cur_bit;
  logic             bit_high_done;
  logic             bit_done;

`ifdef NEOPIXEL_DIM_EN
  assign wr_data = {bus.green >> 2, bus.red >> 2, bus.blue >> 2};
`else
  assign wr_data = {bus.green, bus.red, bus.blue};
`endif

  assign cur_bit      = buffer[pix_cnt][bit_cnt];
  assign bus.ready    = (state == IDLE);
  assign bus.neo_data = neo_q;

  neo_bit_timer #(
    .T0H_CYC   (T0H_CYC),
    .T1H_CYC   (T1H_CYC),
    .BIT_CYC   (BIT_CYC),
    .LATCH_CYC (LATCH_CYC)
  ) u_timer (
    .clock         (clock),
    .reset         (reset),
    .active        (state != IDLE),
    .latching      (state == LATCH),
    .bit_value     (cur_bit),
    .bit_high_done (bit_high_done),
    .bit_done      (bit_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the frame buffer is reset on purpose so a fresh go sends all-zero pixels.
    if (reset) begin
      for (int i = 0; i < NUM_PIXELS; i++) buffer[i] <= '0;
    end else if (state == IDLE && bus.load) begin
      buffer[bus.pixel] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pix_cnt <= '0;
      bit_cnt <= '0;
      neo_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.go) begin
            state   <= BIT_HI;
            pix_cnt <= '0;
            bit_cnt <= TOP_BIT;
            neo_q   <= 1'b1;
          end
        end
        BIT_HI: begin
          if (bit_high_done) begin
            state <= BIT_LO;
            neo_q <= 1'b0;
          end
        end
        BIT_LO: begin
          if (bit_done) begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              state   <= BIT_HI;
              neo_q   <= 1'b1;
            end else if (pix_cnt == LAST_PIX) begin
              pix_cnt <= '0;
              state   <= LATCH;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
              bit_cnt <= TOP_BIT;
              state   <= BIT_HI;
              neo_q   <= 1'b1;
            end
          end
        end
        LATCH: begin
          if (bit_done) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          neo_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_controller.sv
// Cycle-accurate scoreboard bench for neopixel_controller (shortened timing parameters).
module tb_neopixel_controller;
  import neopixel_pkg::*;

  localparam int T0H       = 5;
  localparam int T1H       = 11;
  localparam int BITC      = 16;
  localparam int LATCHC    = 100;
  localparam int FRAME_LEN = NUM_PIXELS * 24 * BITC + LATCHC + 1;

  logic clock = 1'b0;
  logic reset;

  neopixel_if bus ();

  neopixel_controller #(
    .T0H_CYC   (T0H),
    .T1H_CYC   (T1H),
    .BIT_CYC   (BITC),
    .LATCH_CYC (LATCHC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int         n_asserts  = 0;
  int         n_fails    = 0;
  int         stream_idx = 0;
  grb_t       model [NUM_PIXELS];
  logic [1:0] exp_q [$];  // {ready, neo_data} per clock cycle
  logic [1:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic grb_t pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
`ifdef NEOPIXEL_DIM_EN
    return {g >> 2, r >> 2, b >> 2};
`else
    return {g, r, b};
`endif
  endfunction

  // Expected waveform of one frame from the first high cycle to the first idle cycle.
  task automatic push_frame();
    grb_t w;
    int   h;
    for (int p = 0; p < NUM_PIXELS; p++) begin
      w = model[p];
      for (int b = 23; b >= 0; b--) begin
        h = w[b] ? T1H : T0H;
        for (int k = 0; k < h; k++)        exp_q.push_back(2'b01);
        for (int k = h; k < BITC; k++)     exp_q.push_back(2'b00);
      end
    end
    for (int k = 0; k < LATCHC; k++) exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      check($sformatf("stream[%0d] {ready,neo}", stream_idx),
            32'({bus.ready, bus.neo_data}), 32'(mon_exp));
      stream_idx++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_load(input logic [2:0] p, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b);
    bus.pixel = p;
    bus.red   = r;
    bus.green = g;
    bus.blue  = b;
    bus.load  = 1'b1;
  endtask

  task automatic do_load(input logic [2:0] p, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
    set_load(p, r, g, b);
    tick();
    bus.load = 1'b0;
    model[p] = pack(r, g, b);
  endtask

  task automatic start_frame();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    push_frame();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2 * FRAME_LEN + 10) begin
      @(posedge clock);
      n++;
    end
    #1;
    check({tag, " drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check({tag, " idle ready"}, 32'(bus.ready), 32'd1);
    check({tag, " idle neo"}, 32'(bus.neo_data), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.pixel = '0;
    bus.red   = '0;
    bus.green = '0;
    bus.blue  = '0;
    bus.load  = 1'b0;
    bus.go    = 1'b0;
    for (int i = 0; i < NUM_PIXELS; i++) model[i] = '0;

    repeat (3) tick();
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset neo", 32'(bus.neo_data), 32'd0);
    reset = 1'b0;
    tick();

    // Zero frame straight after reset.
    start_frame();
    wait_drain("zero frame");

    // Long-high G bits on pixel 0 and a full latch after pixel 7.
    do_load(3'd0, 8'h00, 8'hFF, 8'h00);
    do_load(3'd7, 8'd32, 8'd32, 8'd32);
    check("no tx after load", 32'(bus.neo_data), 32'd0);
    start_frame();
    wait_drain("g_ff frame");

    // Same-edge load+go, then load/go pulses mid-frame that must be ignored.
    set_load(3'd3, 8'h00, 8'h00, 8'h01);
    bus.go = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.go   = 1'b0;
    model[3] = pack(8'h00, 8'h00, 8'h01);
    push_frame();
    repeat (200) tick();
    set_load(3'd2, 8'hAA, 8'hBB, 8'hCC);
    bus.go = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.go   = 1'b0;
    wait_drain("same-edge frame");

    // go held high: two frames separated only by the latch and one idle cycle.
    bus.go = 1'b1;
    tick();
    push_frame();
    push_frame();
    repeat (FRAME_LEN) @(posedge clock);
    #1;
    bus.go = 1'b0;
    wait_drain("back-to-back");

    // Reset in the high phase of bit 50 aborts immediately.
    start_frame();
    repeat (50 * BITC) @(posedge clock);
    #2;
    exp_q.delete();
    check("bit50 high", 32'(bus.neo_data), 32'd1);
    reset = 1'b1;
    #1;
    check("abort neo", 32'(bus.neo_data), 32'd0);
    check("abort ready", 32'(bus.ready), 32'd1);
    for (int i = 0; i < NUM_PIXELS; i++) model[i] = '0;
    tick();
    reset = 1'b0;
    tick();

    // Buffer must be cleared by the reset.
    start_frame();
    wait_drain("post-reset frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/neopixel_controller.md
NEOPIXEL_CONTROLLER -- requirements
Module: neopixel_controller

Interface
REQ-001 Parameter T0H_CYC, default 18: high-time clock cycles for a 0 bit (0.36 us at 50 MHz).
REQ-002 Parameter T1H_CYC, default 40: high-time clock cycles for a 1 bit (0.80 us).
REQ-003 Parameter BIT_CYC, default 63: total clock cycles per bit (1.26 us).
REQ-004 Parameter LATCH_CYC, default 2600: low clock cycles after the last bit (52 us).
REQ-005 Reset is named reset, is asynchronous and is active-high; the clock is named clock.
REQ-006 clock  in  1  system clock, 50 MHz, rising-edge.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 pixel  in  3  frame-buffer index (0..7) for load.
REQ-009 red, green, blue  in  8 each  colour bytes for load.
REQ-010 load  in  1  write {green,red,blue} to buffer[pixel].
REQ-011 go  in  1  start transmission of the whole frame.
REQ-012 ready  out  1  high = idle and accepting load/go.
REQ-013 neo_data  out  1  serial WS2812 data line, registered output.

Function
REQ-014 States SHALL be IDLE, BIT_HI, BIT_LO, LATCH; ready = (state==IDLE).
REQ-015 IDLE + load: buffer[pixel] SHALL take {green,red,blue} (24 b, G in [23:16]) at that edge; other entries unchanged.
REQ-016 IDLE + go: next state SHALL be BIT_HI with pixel counter 0 and bit counter 23; neo_data rises in the cycle after the go edge.
REQ-017 Same-edge load+go in IDLE: the write SHALL complete first, so the frame carries the new value.
REQ-018 load or go while ready=0 SHALL be ignored, with no buffer change and no restart.
REQ-019 BIT_HI: neo_data=1 for T1H_CYC cycles if the current bit is 1, else T0H_CYC; then BIT_LO.
REQ-020 BIT_LO: neo_data=0 until the bit totals BIT_CYC cycles; then next bit or pixel.
REQ-021 Order: pixel 0..7; within a pixel, bit 23 down to bit 0 (G MSB first, then R, then B).
REQ-022 After bit 0 of pixel 7: LATCH, with neo_data=0 for LATCH_CYC cycles, then IDLE.
REQ-023 Frame length SHALL be exactly 192*BIT_CYC + LATCH_CYC cycles from the first neo_data high to ready high.
REQ-024 The cycle counter SHALL reset to 0 at every bit boundary; there is no cumulative drift between bits.
REQ-025 Counters SHALL be sized for their parameter maxima; the pixel counter wraps 7→0 only on transition to LATCH.
REQ-026 go held high across frames SHALL start a new frame on the first IDLE cycle, giving back-to-back frames separated only by the latch.

Reset
REQ-027 Reset SHALL force state=IDLE, ready=1, neo_data=0, all counters 0, and all buffer entries 24'h000000.
REQ-028 Reset mid-frame SHALL abort immediately; neo_data is low from the reset edge, and a partial frame on the strip is acceptable.

Configuration
REQ-029 Macro NEOPIXEL_DIM_EN defined: each of the red, green and blue bytes SHALL be right-shifted by 2 (zero-fill) on write, e.g. 32→8.
REQ-030 NEOPIXEL_DIM_EN undefined: bytes SHALL be stored unmodified.

Structure
REQ-031 Package neopixel_pkg SHALL hold NUM_PIXELS=8, the default timing constants, the state enum type, and a 24-bit grb_t typedef.
REQ-032 Sub-module neo_bit_timer SHALL contain the cycle counter and produce the bit-high and bit-done strobes from the bit value and parameters.
REQ-033 The 8x24 frame buffer SHALL be flip-flops inside neopixel_controller.

Verification
REQ-034 Reset, then observe → ready=1, neo_data=0, frame of all-zero bytes on the first go.
REQ-035 load pixel=0 G=8'hFF R=0 B=0, then go → first 8 bits each 40 cycles high / 23 cycles low, and the next 184 bits each 18 high / 45 low.
REQ-036 load pixel=7 R=32 G=32 B=32, then go → neo_data low for 2600 cycles after the last bit; ready rises at cycle 192*63+2600 from the first rising edge.
REQ-037 Same-edge load (pixel=3, blue=8'h01) and go → pixel 3 bit 0 is a 1 (40-cycle high).
REQ-038 go and load (pixel=2) pulsed mid-frame → frame unaffected and buffer[2] unchanged on the next frame; assert reset at bit 50 → neo_data=0 and ready=1 immediately.
REQ-039 With NEOPIXEL_DIM_EN defined, load R=G=B=32 → transmitted bytes are 8 (8'b00001000).
